conv_layer_sequencer: RTL and testbench
=======================================

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1048576, meaning pass/drain watchdog limit in clk cycles.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle layer launch request.
REQ-005 SHALL have port Image_size  input  8  feature-map side (4, 8, 16, 32, 64 or 128).
REQ-006 SHALL have port in_channels  input  9  input channel count (64, 128 or 256).
REQ-007 SHALL have port out_channels  input  9  output channel count (64, 128 or 256).
REQ-008 SHALL have port pass_start  output  1  one-cycle pulse launching one 3x3 convolution pass.
REQ-009 SHALL have port pass_first  output  1  current pass is in-channel 0 (datapath overwrites, no accumulate).
REQ-010 SHALL have port pass_last  output  1  current pass is last in-channel (datapath adds bias).
REQ-011 SHALL have port pass_done  input  1  one-cycle pulse: datapath finished current pass.
REQ-012 SHALL have port in_ch_idx  output  9  current input channel index.
REQ-013 SHALL have port out_ch_idx  output  9  current output channel index; also bias address.
REQ-014 SHALL have port kernel_base  output  16  kernel address = out_ch_idx*in_channels + in_ch_idx.
REQ-015 SHALL have port drain_start  output  1  one-cycle pulse: stream output map over master AXI-Stream.
REQ-016 SHALL have port drain_done  input  1  one-cycle pulse: tlast beat accepted downstream.
REQ-017 SHALL have port busy  output  1  high from launch until DONE exits.
REQ-018 SHALL have port layer_done  output  1  one-cycle pulse on completion of all output channels.
REQ-019 SHALL have port error  output  1  sticky fault flag, cleared by next accepted start or reset.

Function
REQ-020 SHALL implement states IDLE, CHECK, LAUNCH, WAIT_PASS, DRAIN, WAIT_DRAIN, DONE, FAULT.
REQ-021 SHALL in IDLE on start=1 latch Image_size/in_channels/out_channels, clear error, go CHECK; config changes after latch SHALL be ignored.
REQ-022 SHALL in CHECK go LAUNCH if latched config is legal, else go FAULT with error=1 and no pass_start ever issued.
REQ-023 SHALL in LAUNCH assert pass_start for exactly one cycle, then go WAIT_PASS.
REQ-024 SHALL hold in_ch_idx, out_ch_idx, kernel_base, pass_first, pass_last stable from LAUNCH until pass_done is sampled.
REQ-025 SHALL in WAIT_PASS on pass_done: if in_ch_idx < in_channels-1, increment in_ch_idx and go LAUNCH; else go DRAIN.
REQ-026 SHALL in DRAIN assert drain_start one cycle, go WAIT_DRAIN; on drain_done, if out_ch_idx < out_channels-1, clear in_ch_idx, increment out_ch_idx, go LAUNCH; else go DONE.
REQ-027 SHALL in DONE assert layer_done one cycle, reset both indices to 0, return IDLE.
REQ-028 SHALL ignore start when not in IDLE, including start coincident with pass_done or drain_done.
REQ-029 SHALL ignore pass_done outside WAIT_PASS and drain_done outside WAIT_DRAIN.
REQ-030 SHALL compute kernel_base as registered value with maximum 255*256+255 = 65535, no overflow.
REQ-031 SHALL leave FAULT to IDLE after one cycle; error remains 1.
REQ-032 SHALL keep busy=1 in every state except IDLE and FAULT.

Reset
REQ-033 SHALL on aresetn=0 at a clock edge enter IDLE from any state, including mid-pass or mid-drain.
REQ-034 SHALL reset all outputs to 0: pass_start, pass_first, pass_last, drain_start, busy, layer_done, error, indices, kernel_base.

Configuration
REQ-035 SHALL gate a watchdog with macro CONV_SEQ_WATCHDOG_EN: when defined, a counter restarts on entering WAIT_PASS/WAIT_DRAIN and, reaching TIMEOUT_CYCLES without the done pulse, forces FAULT with error=1.
REQ-036 SHALL, without CONV_SEQ_WATCHDOG_EN, wait indefinitely in WAIT_PASS/WAIT_DRAIN and contain no watchdog counter.

Verification
REQ-037 SHALL cover: Image_size=4, in=64, out=64, pass_done 20 cycles after each pass_start -> 4096 pass_start, 64 drain_start, one layer_done, final kernel_base 4095.
REQ-038 SHALL cover: in=64 -> pass_first=1 only at in_ch_idx=0, pass_last=1 only at in_ch_idx=63, per output channel.
REQ-039 SHALL cover: Image_size=12 or in_channels=100 -> error=1, zero pass_start, busy=0 after FAULT.
REQ-040 SHALL cover: start pulsed during WAIT_PASS and coincident with pass_done -> no restart, indices advance normally.
REQ-041 SHALL cover: aresetn=0 during WAIT_DRAIN of out_ch 5 -> next cycle IDLE, all outputs 0, new start begins at out_ch_idx 0.
REQ-042 SHALL cover: CONV_SEQ_WATCHDOG_EN defined, TIMEOUT_CYCLES=100, pass_done withheld -> error=1 exactly 100 cycles after entering WAIT_PASS; undefined -> remains WAIT_PASS.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// Layer sequencer for a 3x3 conv datapath: walks every (out_ch, in_ch) pass, then drains each output map.
// Optional pass/drain watchdog enabled by defining CONV_SEQ_WATCHDOG_EN.
module conv_layer_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [7:0]  Image_size,
  input  logic [8:0]  in_channels,
  input  logic [8:0]  out_channels,
  output logic        pass_start,
  output logic        pass_first,
  output logic        pass_last,
  input  logic        pass_done,
  output logic [8:0]  in_ch_idx,
  output logic [8:0]  out_ch_idx,
  output logic [15:0] kernel_base,
  output logic        drain_start,
  input  logic        drain_done,
  output logic        busy,
  output logic        layer_done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_PASS,
    S_DRAIN,
    S_WAIT_DRAIN,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  img_q;
  logic [8:0]  cin_q, cout_q;
  logic [8:0]  in_idx_q, in_idx_d;
  logic [8:0]  out_idx_q, out_idx_d;
  logic [15:0] kb_q, kb_d;
  logic        err_q, err_d;
  logic        pass_start_q, pass_first_q, pass_last_q;
  logic        drain_start_q, busy_q, layer_done_q;
  logic        cfg_ok, more_in, more_out, wd_expire;

  assign cfg_ok = (img_q inside {8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128}) &&
                  (cin_q inside {9'd64, 9'd128, 9'd256}) &&
                  (cout_q inside {9'd64, 9'd128, 9'd256});
  assign more_in  = (in_idx_q + 9'd1) < cin_q;
  assign more_out = (out_idx_q + 9'd1) < cout_q;

  // Passes run in kernel-address order, so out*in_channels+in advances by exactly one per pass.
  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    kb_d      = kb_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CHECK;
          err_d     = 1'b0;
          in_idx_d  = '0;
          out_idx_d = '0;
          kb_d      = '0;
        end
      end
      S_CHECK: begin
        if (cfg_ok) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end
      end
      S_LAUNCH: state_d = S_WAIT_PASS;
      S_WAIT_PASS: begin
        if (pass_done) begin
          if (more_in) begin
            in_idx_d = in_idx_q + 9'd1;
            kb_d     = kb_q + 16'd1;
            state_d  = S_LAUNCH;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (wd_expire) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: state_d = S_WAIT_DRAIN;
      S_WAIT_DRAIN: begin
        if (drain_done) begin
          if (more_out) begin
            in_idx_d  = '0;
            out_idx_d = out_idx_q + 9'd1;
            kb_d      = kb_q + 16'd1;
            state_d   = S_LAUNCH;
          end else begin
            state_d = S_DONE;
          end
        end else if (wd_expire) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        in_idx_d  = '0;
        out_idx_d = '0;
        kb_d      = '0;
      end
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      img_q         <= '0;
      cin_q         <= '0;
      cout_q        <= '0;
      in_idx_q      <= '0;
      out_idx_q     <= '0;
      kb_q          <= '0;
      err_q         <= 1'b0;
      pass_start_q  <= 1'b0;
      pass_first_q  <= 1'b0;
      pass_last_q   <= 1'b0;
      drain_start_q <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      kb_q      <= kb_d;
      err_q     <= err_d;
      if (state_q == S_IDLE && start) begin
        img_q  <= Image_size;
        cin_q  <= in_channels;
        cout_q <= out_channels;
      end
      pass_start_q  <= (state_d == S_LAUNCH);
      drain_start_q <= (state_d == S_DRAIN);
      layer_done_q  <= (state_d == S_DONE);
      busy_q        <= !(state_d inside {S_IDLE, S_FAULT});
      // Pass flags are set on entry to LAUNCH and held through the pass and the drain that follows.
      if (state_d == S_LAUNCH && state_q != S_LAUNCH) begin
        pass_first_q <= (in_idx_d == '0);
        pass_last_q  <= ((in_idx_d + 9'd1) == cin_q);
      end else if (state_d == S_DONE || state_d == S_FAULT) begin
        pass_first_q <= 1'b0;
        pass_last_q  <= 1'b0;
      end
    end
  end

`ifdef CONV_SEQ_WATCHDOG_EN
  logic [31:0] wd_q;
  logic        in_wait;

  assign in_wait   = (state_q == S_WAIT_PASS) || (state_q == S_WAIT_DRAIN);
  assign wd_expire = in_wait && (wd_q == (TIMEOUT_CYCLES - 32'd1));

  // Restarts on every entry to a wait state; counts only while the wait persists.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wd_q <= '0;
    end else if (in_wait && state_d == state_q) begin
      wd_q <= wd_q + 32'd1;
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  assign pass_start  = pass_start_q;
  assign pass_first  = pass_first_q;
  assign pass_last   = pass_last_q;
  assign drain_start = drain_start_q;
  assign busy        = busy_q;
  assign layer_done  = layer_done_q;
  assign error       = err_q;
  assign in_ch_idx   = in_idx_q;
  assign out_ch_idx  = out_idx_q;
  assign kernel_base = kb_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: config table, full 64x64 layer, ignore/reset corners, watchdog.
module tb_conv_layer_sequencer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  Image_size = '0;
  logic [8:0]  in_channels = '0;
  logic [8:0]  out_channels = '0;
  logic        pass_done = 1'b0;
  logic        drain_done = 1'b0;
  logic        pass_start, pass_first, pass_last, drain_start, busy, layer_done, error;
  logic [8:0]  in_ch_idx, out_ch_idx;
  logic [15:0] kernel_base;

  conv_layer_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .aresetn(aresetn), .start(start),
    .Image_size(Image_size), .in_channels(in_channels), .out_channels(out_channels),
    .pass_start(pass_start), .pass_first(pass_first), .pass_last(pass_last),
    .pass_done(pass_done), .in_ch_idx(in_ch_idx), .out_ch_idx(out_ch_idx),
    .kernel_base(kernel_base), .drain_start(drain_start), .drain_done(drain_done),
    .busy(busy), .layer_done(layer_done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_ps = 0, n_ds = 0, n_ld = 0;
  int last_kb = 0;

  always @(negedge clk) begin
    if (pass_start === 1'b1) n_ps <= n_ps + 1;
    if (drain_start === 1'b1) n_ds <= n_ds + 1;
    if (layer_done === 1'b1) n_ld <= n_ld + 1;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: sig = pass_start;
      1: sig = drain_start;
      default: sig = layer_done;
    endcase
  endfunction

  task automatic wait_high(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (sig(which) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic launch(input logic [7:0] img, input logic [8:0] cin, input logic [8:0] cout);
    Image_size = img; in_channels = cin; out_channels = cout;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_pass(input int ei, input int eo, input int cin, input int lat,
                         input bit st, input bit noise, output int bad);
    bit ok;
    logic [8:0] si, so;
    logic [15:0] sk;
    logic sf, sl;
    bad = 0;
    wait_high(0, 20, ok);
    if (!ok) begin
      bad = 1;
      return;
    end
    if (in_ch_idx !== 9'(ei) || out_ch_idx !== 9'(eo) || kernel_base !== 16'(eo * cin + ei) ||
        pass_first !== (ei == 0) || pass_last !== (ei == cin - 1))
      bad++;
    last_kb = int'(kernel_base);
    si = in_ch_idx; so = out_ch_idx; sk = kernel_base; sf = pass_first; sl = pass_last;
    tick();
    for (int k = 0; k < lat; k++) begin
      if (st && k == 0) start = 1'b1;
      if (noise && k == 1) drain_done = 1'b1;
      tick();
      start = 1'b0;
      drain_done = 1'b0;
      if (pass_start !== 1'b0 || busy !== 1'b1 || in_ch_idx !== si || out_ch_idx !== so ||
          kernel_base !== sk || pass_first !== sf || pass_last !== sl)
        bad++;
    end
    pass_done = 1'b1;
    start = st;
    tick();
    pass_done = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_drain(input int lat, input bit st, input bit noise, output int bad);
    bit ok;
    bad = 0;
    wait_high(1, 20, ok);
    if (!ok) begin
      bad = 1;
      return;
    end
    tick();
    for (int k = 0; k < lat; k++) begin
      if (noise && k == 0) pass_done = 1'b1;
      tick();
      pass_done = 1'b0;
      if (busy !== 1'b1 || pass_start !== 1'b0 || drain_start !== 1'b0) bad++;
    end
    drain_done = 1'b1;
    start = st;
    tick();
    drain_done = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_out(input int o, input int cin, input int lat, input bit noise, output int bad);
    int b;
    bad = 0;
    for (int i = 0; i < cin; i++) begin
      do_pass(i, o, cin, lat, 1'b0, noise, b);
      bad += b;
    end
    do_drain(lat, 1'b0, noise, b);
    bad += b;
  endtask

  typedef struct {
    logic [7:0] img;
    logic [8:0] cin;
    logic [8:0] cout;
    logic [2:0] exp_status;  // {pass_start, busy, error} one edge after CHECK
    logic [1:0] exp_late;    // {busy, error} a few cycles later
    int         exp_passes;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int bad, b, p0, d0, l0, n_err;
    bit ok;

    tbl[0]  = '{8'd12,  9'd64,  9'd64,  3'b001, 2'b01, 0};
    tbl[1]  = '{8'd4,   9'd64,  9'd64,  3'b110, 2'b10, 1};
    tbl[2]  = '{8'd4,   9'd100, 9'd64,  3'b001, 2'b01, 0};
    tbl[3]  = '{8'd128, 9'd256, 9'd256, 3'b110, 2'b10, 1};
    tbl[4]  = '{8'd4,   9'd64,  9'd100, 3'b001, 2'b01, 0};
    tbl[5]  = '{8'd64,  9'd128, 9'd64,  3'b110, 2'b10, 1};
    tbl[6]  = '{8'd2,   9'd64,  9'd64,  3'b001, 2'b01, 0};
    tbl[7]  = '{8'd255, 9'd64,  9'd64,  3'b001, 2'b01, 0};
    tbl[8]  = '{8'd8,   9'd32,  9'd64,  3'b001, 2'b01, 0};
    tbl[9]  = '{8'd32,  9'd256, 9'd128, 3'b110, 2'b10, 1};
    tbl[10] = '{8'd16,  9'd64,  9'd511, 3'b001, 2'b01, 0};
    tbl[11] = '{8'd4,   9'd0,   9'd64,  3'b001, 2'b01, 0};

    repeat (3) tick();
    check("reset_flags", 64'({pass_start, pass_first, pass_last, drain_start, busy, layer_done, error}), 64'd0);
    check("reset_regs", 64'({in_ch_idx, out_ch_idx, kernel_base}), 64'd0);
    aresetn = 1'b1;
    tick();

    // Config table: launch, scramble the inputs after latch, check legality outcome.
    for (int v = 0; v < 12; v++) begin
      p0 = n_ps;
      launch(tbl[v].img, tbl[v].cin, tbl[v].cout);
      Image_size = tbl[v].exp_passes != 0 ? 8'd12 : 8'd4;
      in_channels = tbl[v].exp_passes != 0 ? 9'd100 : 9'd64;
      out_channels = 9'd64;
      tick();
      check($sformatf("vec%0d_status", v), 64'({pass_start, busy, error}), 64'(tbl[v].exp_status));
      repeat (4) tick();
      check($sformatf("vec%0d_late", v), 64'({busy, error}), 64'(tbl[v].exp_late));
      check($sformatf("vec%0d_passes", v), 64'(n_ps - p0), 64'(tbl[v].exp_passes));
      if (tbl[v].exp_passes != 0) begin
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
      end
      Image_size = '0; in_channels = '0; out_channels = '0;
    end

    // Full 64x64 layer.
    p0 = n_ps; d0 = n_ds; l0 = n_ld; bad = 0;
    launch(8'd4, 9'd64, 9'd64);
    for (int o = 0; o < 64; o++) begin
      run_out(o, 64, 3, 1'b0, b);
      bad += b;
    end
    wait_high(2, 20, ok);
    check("full_layer_done_seen", 64'(ok), 64'd1);
    tick();
    check("full_pass_fields", 64'(bad), 64'd0);
    check("full_pass_starts", 64'(n_ps - p0), 64'd4096);
    check("full_drain_starts", 64'(n_ds - d0), 64'd64);
    check("full_layer_dones", 64'(n_ld - l0), 64'd1);
    check("full_last_kb", 64'(last_kb), 64'd4095);
    check("full_idle_after", 64'({busy, error, in_ch_idx, out_ch_idx, kernel_base}), 64'd0);

    // Ignored start/done pulses, then reset mid-drain of out_ch 5.
    bad = 0;
    launch(8'd8, 9'd64, 9'd64);
    do_pass(0, 0, 64, 4, 1'b1, 1'b1, b);
    bad += b;
    for (int i = 1; i < 64; i++) begin
      do_pass(i, 0, 64, 2, 1'b0, 1'b1, b);
      bad += b;
    end
    do_drain(3, 1'b1, 1'b1, b);
    bad += b;
    for (int o = 1; o < 5; o++) begin
      run_out(o, 64, 2, 1'b1, b);
      bad += b;
    end
    for (int i = 0; i < 64; i++) begin
      do_pass(i, 5, 64, 2, 1'b0, 1'b0, b);
      bad += b;
    end
    check("ignore_seq_fields", 64'(bad), 64'd0);
    wait_high(1, 20, ok);
    tick();
    tick();
    check("pre_reset_wait_drain", 64'({busy, out_ch_idx, drain_start}), 64'({1'b1, 9'd5, 1'b0}));
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("mid_drain_reset_flags", 64'({pass_start, pass_first, pass_last, drain_start, busy, layer_done, error}), 64'd0);
    check("mid_drain_reset_regs", 64'({in_ch_idx, out_ch_idx, kernel_base}), 64'd0);
    launch(8'd4, 9'd64, 9'd64);
    do_pass(0, 0, 64, 2, 1'b0, 1'b0, b);
    check("restart_first_pass", 64'(b), 64'd0);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    // Withheld pass_done: watchdog fires after 100 cycles, or the wait persists.
    launch(8'd4, 9'd64, 9'd64);
    wait_high(0, 10, ok);
    tick();
    n_err = 0;
    for (int n = 1; n <= 150; n++) begin
      tick();
      if (error === 1'b1) begin
        n_err = n;
        break;
      end
    end
`ifdef CONV_SEQ_WATCHDOG_EN
    check("wd_fire_cycle", 64'(n_err), 64'd100);
    tick();
    check("wd_after_fault", 64'({busy, error}), 64'b01);
`else
    check("no_wd_error", 64'(n_err), 64'd0);
    check("no_wd_still_waiting", 64'({busy, error, pass_start}), 64'b100);
`endif
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
